// File: rtl/cntry_vehicle_sensor.sv
// Country-road vehicle sensor: synchronises and debounces the loop detector,
// queues arriving vehicles and retires them while the country light is GREEN.
// X is high while vehicles are queued.
// Optional feature (define CNTRY_MAX_GREEN_EN): after MAX_GREEN consecutive
// green cycles X is forced low until the country light leaves GREEN.
module cntry_vehicle_sensor #(
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned DEPART_CYCLES = 3,
  parameter int unsigned QW            = 4,
  parameter int unsigned MAX_GREEN     = 12
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          veh_raw,
  input  logic [1:0]    cntry,
  output logic          X,
  output logic [QW-1:0] queue_count,
  output logic          arrival,
  output logic          departure,
  output logic          ovf
);

  localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [1:0]    GREEN = 2'd2;
  localparam logic [QW-1:0] QMAX  = '1;

  logic          s1, s2, stable;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] ttmr;
  logic [QW-1:0] q_next;
  logic          ovf_next;
  logic          is_green;
  logic          timer_run;
  logic          x_next;

  assign is_green = (cntry == GREEN);

  // Synchroniser, debounce and arrival pulse on an accepted 0->1 transition
  always_ff @(posedge clock) begin
    if (clear) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      stable  <= 1'b0;
      dcnt    <= '0;
      arrival <= 1'b0;
    end else begin
      s1      <= veh_raw;
      s2      <= s1;
      arrival <= 1'b0;
      if (s2 == stable) begin
        dcnt <= '0;
      end else if (dcnt == DW'(DEBOUNCE - 1)) begin
        stable  <= s2;
        dcnt    <= '0;
        arrival <= s2;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  // Next queue value: collision holds, saturate at top, guard at zero
  always_comb begin
    q_next   = queue_count;
    ovf_next = ovf;
    if (arrival && !departure) begin
      if (queue_count == QMAX) begin
        ovf_next = 1'b1;
      end else begin
        q_next = queue_count + QW'(1);
      end
    end else if (departure && !arrival && (queue_count != '0)) begin
      q_next = queue_count - QW'(1);
    end
  end

  // Timer also stops when the last queued vehicle is already retiring
  assign timer_run = is_green && (queue_count != '0) && (q_next != '0);

  // Departure timer: one departure per DEPART_CYCLES of continuous green
  always_ff @(posedge clock) begin
    if (clear) begin
      ttmr      <= '0;
      departure <= 1'b0;
    end else begin
      departure <= 1'b0;
      if (!timer_run) begin
        ttmr <= '0;
      end else if (ttmr == TW'(DEPART_CYCLES - 1)) begin
        ttmr      <= '0;
        departure <= 1'b1;
      end else begin
        ttmr <= ttmr + TW'(1);
      end
    end
  end

`ifdef CNTRY_MAX_GREEN_EN
  localparam int unsigned GW = $clog2(MAX_GREEN + 1);
  logic [GW-1:0] gcnt;

  // Consecutive-green counter, saturating at MAX_GREEN
  always_ff @(posedge clock) begin
    if (clear) begin
      gcnt <= '0;
    end else if (!is_green) begin
      gcnt <= '0;
    end else if (gcnt != GW'(MAX_GREEN)) begin
      gcnt <= gcnt + GW'(1);
    end
  end

  assign x_next = (q_next != '0) && !(is_green && (gcnt == GW'(MAX_GREEN)));
`else
  assign x_next = (q_next != '0);
`endif

  // Queue, sticky overflow and registered vehicle-present flag
  always_ff @(posedge clock) begin
    if (clear) begin
      queue_count <= '0;
      ovf         <= 1'b0;
      X           <= 1'b0;
    end else begin
      queue_count <= q_next;
      ovf         <= ovf_next;
      X           <= x_next;
    end
  end

endmodule

// File: doc/cntry_vehicle_sensor.md
Name: cntry_vehicle_sensor

Overview:
- Producer of the country-road car-present signal `X` that the highway/country signal controller consumes.
- Conditions a raw loop-detector input: 2-flop synchroniser, then debounce.
- Counts vehicles queued on the country road and retires them while the country light is GREEN.
- Holds `X` high while the queue is non-empty.
- Observes the controller's `cntry` light output to close the loop.

Parameters:
- DEBOUNCE, 4: consecutive cycles the synchronised input must differ from the stable value before it is accepted (min 2).
- DEPART_CYCLES, 3: cycles of continuous country GREEN per departing vehicle (min 1).
- QW, 4: queue counter width; saturates at 2^QW-1.
- MAX_GREEN, 12: green limit in cycles; used only with the optional feature.

Ports:
- clock  input  1  system clock, rising edge
- clear  input  1  synchronous, active-high reset
- veh_raw  input  1  asynchronous loop-detector level; 1 = vehicle over loop
- cntry  input  2  country light from controller: 2'd0 RED, 2'd1 YELLOW, 2'd2 GREEN; 2'd3 treated as RED
- X  output  1  vehicle waiting/present on country road
- queue_count  output  QW  vehicles currently queued
- arrival  output  1  one-cycle pulse per accepted vehicle
- departure  output  1  one-cycle pulse per retired vehicle
- ovf  output  1  sticky: an arrival was dropped at saturation

Behaviour:
- Interface: one clock, `clock`; reset `clear` is synchronous and active-high. All state updates occur on rising `clock` only.
- Reset (`clear`=1 at an edge) forces:
  - sync flops = 0, stable level = 0, all counters = 0;
  - X=0, queue_count=0, arrival=0, departure=0, ovf=0.
- Reset mid-operation discards the queue and any partial debounce or departure timing.
- Synchroniser: s1<=veh_raw, s2<=s1.
- Debounce, applied each edge:
  - if s2==stable: dcnt<=0;
  - else if dcnt==DEBOUNCE-1: stable<=s2, dcnt<=0;
  - else dcnt<=dcnt+1.
  - A differing s2 run shorter than DEBOUNCE cycles is rejected.
- Arrival:
  - `arrival` is registered high on the edge where stable goes 0->1.
  - queue_count increments on the following edge.
  - Latency from veh_raw rising (held steady) to queue_count increment: DEBOUNCE+3 edges.
  - A 1->0 stable transition generates nothing.
- Departure timer `ttmr`:
  - Runs only while cntry==GREEN and queue_count>0; otherwise ttmr<=0.
  - When ttmr==DEPART_CYCLES-1: departure<=1, ttmr<=0.
  - queue_count decrements on the edge after `departure`.
  - A departure is never issued while the queue is 0.
- Simultaneous arrival and departure in the same update cycle: queue_count unchanged, ovf unchanged.
- Saturation: an arrival while queue_count==2^QW-1 (with no departure that cycle) is dropped and ovf<=1. ovf clears only on `clear`.
- Queue wrap-around never occurs: the counter saturates at the top and is guarded at zero.
- X is derived from registered state only (no combinational path from veh_raw or cntry): X = (queue_count != 0).
  - X rises the edge queue_count leaves 0.
  - X falls the edge queue_count returns to 0.
- cntry YELLOW/RED mid-queue: timer clears and the queue is held. Departures resume from ttmr=0 at the next GREEN.

Optional Feature:
- Macro: CNTRY_MAX_GREEN_EN.
- Defined:
  - A green counter counts consecutive cycles with cntry==GREEN and clears when cntry!=GREEN.
  - Once it reaches MAX_GREEN, X is forced 0 until cntry leaves GREEN. This makes the controller yield to the highway.
  - queue_count, arrival and departure behave unchanged.
  - X returns to (queue_count!=0) on the first cycle cntry!=GREEN.
- Not defined: no green counter exists and X = (queue_count!=0) always.

Test Plan:
- Reset: drive veh_raw=1, clear=1 for 2 edges -> X=0, queue_count=0, ovf=0. Release clear, DEBOUNCE=4 -> arrival pulse, then queue_count=1 and X=1 exactly 7 edges after release.
- Glitch reject: veh_raw high for 3 cycles then low, cntry=RED -> no arrival; queue_count stays 0; X stays 0.
- Three cars: three clean 8-cycle pulses separated by 8 low cycles, cntry=RED -> queue_count=3. Then cntry=GREEN -> departures at green cycles 3, 6, 9. queue_count reaches 0 and X falls one edge after the third departure.
- Arrival/departure collision: align an arrival pulse with a departure pulse while queue_count=2 -> queue_count stays 2. Green interrupted (cntry=YELLOW) after 2 green cycles -> no departure; ttmr restarts from 0 on the next GREEN.
- Saturation (QW=4): 16 arrivals with cntry=RED -> queue_count=15, ovf=1 after the 16th. ovf stays 1 after the queue drains, and clears only on clear.
- CNTRY_MAX_GREEN_EN, DEPART_CYCLES=3, MAX_GREEN=12: queue_count=10, cntry=GREEN held -> X=0 after 12 green cycles with queue_count=6. X=1 on the first cycle cntry=YELLOW.
